// File: rtl/adder_arb_pkg.sv
// rtl/adder_arb_pkg.sv - shared types and constants for adder_arbiter (saturation under ADDER_ARB_SAT_EN)
package adder_arb_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        FULL = 1'b1
    } state_t;

    localparam int DEF_DW   = 16;
    localparam int DEF_NREQ = 3;

    // Saturation limits at the default width; the top stretches them to DW.
    localparam logic [DEF_DW-1:0] SAT_POS = 16'h7FFF;
    localparam logic [DEF_DW-1:0] SAT_NEG = 16'h8000;

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - round-robin one-hot grant, search starts after ptr and wraps
module rr_arbiter #(
    parameter int NREQ = 3
) (
    input  logic [NREQ-1:0] req,
    input  logic [1:0]      ptr,
    output logic [NREQ-1:0] grant
);

    logic       found;
    logic [1:0] idx;

    always_comb begin
        grant = '0;
        found = 1'b0;
        idx   = '0;
        for (int k = 1; k <= NREQ; k++) begin
            idx = 2'((int'(ptr) + k) % NREQ);
            if (!found && req[idx]) begin
                grant[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/adder_arbiter.sv
// rtl/adder_arbiter.sv - shared add/sub unit with round-robin requesters and one result register (ADDER_ARB_SAT_EN: saturate on overflow)
module adder_arbiter
    import adder_arb_pkg::*;
#(
    parameter int NREQ = DEF_NREQ,
    parameter int DW   = DEF_DW
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [NREQ-1:0]  req_valid,
    input  logic [NREQ-1:0]  req_mode,
    input  logic [NREQ*DW-1:0] req_a,
    input  logic [NREQ*DW-1:0] req_b,
    output logic [NREQ-1:0]  req_ready,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [1:0]       rsp_id,
    output logic [DW-1:0]    rsp_sum,
    output logic             rsp_n,
    output logic             rsp_v,
    output logic             rsp_z
);

    state_t          state;
    logic [1:0]      ptr;
    logic [NREQ-1:0] grant;
    logic            can_accept;
    logic            transfer;

    logic [DW-1:0]   a_sel;
    logic [DW-1:0]   b_sel;
    logic            mode_sel;
    logic [1:0]      gidx;
    logic [DW-1:0]   b_eff;
    logic [DW-1:0]   sum_raw;
    logic [DW-1:0]   sum_res;
    logic            ovf;

    rr_arbiter #(.NREQ(NREQ)) u_rr (
        .req   (req_valid),
        .ptr   (ptr),
        .grant (grant)
    );

    // A held result blocks new grants unless it is being drained this cycle.
    assign can_accept = (state == IDLE) || rsp_ready;
    assign req_ready  = (can_accept && !rst) ? grant : '0;
    assign transfer   = |req_ready;
    assign rsp_valid  = (state == FULL);

    always_comb begin
        a_sel    = '0;
        b_sel    = '0;
        mode_sel = 1'b0;
        gidx     = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (req_ready[i]) begin
                a_sel    = req_a[i*DW +: DW];
                b_sel    = req_b[i*DW +: DW];
                mode_sel = req_mode[i];
                gidx     = 2'(i);
            end
        end
    end

    // Subtract folds into the adder as A + ~B + 1; overflow compares A with the effective B.
    assign b_eff   = mode_sel ? ~b_sel : b_sel;
    assign sum_raw = a_sel + b_eff + DW'(mode_sel);
    assign ovf     = (a_sel[DW-1] == b_eff[DW-1]) && (sum_raw[DW-1] != a_sel[DW-1]);

`ifdef ADDER_ARB_SAT_EN
    localparam logic [DW-1:0] SAT_POS_W = {SAT_POS[DEF_DW-1], {(DW-1){SAT_POS[0]}}};
    localparam logic [DW-1:0] SAT_NEG_W = {SAT_NEG[DEF_DW-1], {(DW-1){SAT_NEG[0]}}};
    assign sum_res = ovf ? (a_sel[DW-1] ? SAT_NEG_W : SAT_POS_W) : sum_raw;
`else
    assign sum_res = sum_raw;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            ptr     <= 2'(NREQ - 1);
            rsp_id  <= '0;
            rsp_sum <= '0;
            rsp_n   <= 1'b0;
            rsp_v   <= 1'b0;
            rsp_z   <= 1'b0;
        end else if (transfer) begin
            state   <= FULL;
            ptr     <= gidx;
            rsp_id  <= gidx;
            rsp_sum <= sum_res;
            rsp_n   <= sum_res[DW-1];
            rsp_v   <= ovf;
            rsp_z   <= (sum_res == '0);
        end else if (rsp_ready) begin
            state <= IDLE;
        end
    end

endmodule

// File: doc/adder_arbiter.md
ADDER_ARBITER -- requirements
Module: adder_arbiter

Interface
REQ-001 Parameter NREQ, default 3: number of requesters sharing the adder; legal values 2..4.
REQ-002 Parameter DW, default 16: operand/result width.
REQ-003 clk  input  1  sole clock; all state changes on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 req_valid  input  NREQ  per-requester operation request.
REQ-006 req_mode  input  NREQ  per-requester op: 0 = A+B, 1 = A-B.
REQ-007 req_a, req_b  input  NREQ*DW each  packed operands; requester i uses bits [i*DW +: DW].
REQ-008 req_ready  output  NREQ  one-hot grant; a transfer occurs when req_valid[i] && req_ready[i].
REQ-009 rsp_valid  output  1  result register holds a valid result.
REQ-010 rsp_ready  input  1  consumer accepts the result this cycle.
REQ-011 rsp_id  output  2  index of the requester that owns the result.
REQ-012 rsp_sum  output  DW  registered sum/difference.
REQ-013 rsp_n, rsp_v, rsp_z  output  1 each  registered negative, signed-overflow and zero flags of rsp_sum.

Function
REQ-014 The block SHALL sit in state IDLE (result register empty) or FULL (result register occupied).
REQ-015 req_ready SHALL be all-zero when the result register is FULL and rsp_ready is 0; otherwise it SHALL be one-hot on the winning valid requester, or all-zero if no requester is valid.
REQ-016 Arbitration SHALL be round-robin: search starts at index ptr+1 and wraps modulo NREQ; ptr SHALL be updated to the granted index only on a completed transfer.
REQ-017 req_ready SHALL depend combinationally on req_valid, ptr, state and rsp_ready only, never on operands.
REQ-018 Latency SHALL be one cycle: a transfer at edge t makes rsp_valid=1 with its result at edge t+1.
REQ-019 Throughput SHALL be one operation per cycle while rsp_ready=1; a simultaneous consume and accept SHALL stay in FULL with the new result.
REQ-020 Transitions: IDLE->FULL on transfer; FULL->IDLE on rsp_ready with no transfer; FULL->FULL on rsp_ready with transfer, or on !rsp_ready (result held unchanged).
REQ-021 Arithmetic SHALL be DW-bit two's complement: subtract = A + ~B + 1, carry-out discarded.
REQ-022 rsp_n = sum[DW-1]; rsp_z = (sum == 0); rsp_v = 1 iff operands of effective-same sign yield a result of opposite sign (add: A,B same sign; sub: A,B opposite sign).
REQ-023 While rsp_valid=1 and rsp_ready=0, rsp_id/rsp_sum/flags SHALL remain stable.

Reset
REQ-024 rst=1 at an edge SHALL force state IDLE, rsp_valid=0, rsp_id=0, rsp_sum=0, rsp_n=0, rsp_v=0, rsp_z=0, ptr=NREQ-1 (requester 0 wins first).
REQ-025 Reset mid-operation SHALL discard any held result; req_ready SHALL be all-zero while rst=1.

Configuration
REQ-026 Macro ADDER_ARB_SAT_EN: when defined, on rsp_v=1 rsp_sum SHALL saturate to 0x7FFF (positive overflow) or 0x8000 (negative overflow), with rsp_v still 1 and rsp_n/rsp_z computed from the saturated value; when undefined, rsp_sum SHALL be the wrapped result.

Structure
REQ-027 Package adder_arb_pkg SHALL hold the state typedef (IDLE, FULL), default DW and NREQ, and the saturation constants.
REQ-028 Round-robin grant logic SHALL be one sub-module, rr_arbiter (inputs req, ptr; output one-hot grant); the adder datapath stays inline.

Verification
REQ-029 Reset, then req_valid=001, mode 0, A=0x0003, B=0x0004 -> req_ready=001; next cycle rsp_valid=1, rsp_id=0, rsp_sum=0x0007, N=V=Z=0.
REQ-030 Requester 1 sub, A=0x8000, B=0x0001 -> rsp_sum=0x7FFF, V=1, N=0 (wrap); with ADDER_ARB_SAT_EN -> rsp_sum=0x8000, V=1, N=1.
REQ-031 All three valid continuously, rsp_ready=1 -> grants 001,010,100,001 on consecutive cycles; rsp_id 0,1,2,0.
REQ-032 rsp_ready=0 for 3 cycles with FULL -> req_ready=000, outputs frozen; rsp_ready=1 -> next grant issued same cycle, new result next edge.
REQ-033 A=0x0005, B=0x0005, mode 1 -> rsp_sum=0x0000, Z=1, N=0, V=0.
REQ-034 rst asserted while FULL with rsp_ready=0 -> next cycle rsp_valid=0, all outputs zero, first grant goes to requester 0.
